// File: rtl/core_issue_split_pkg.sv
// Shared core types for the fetch/issue/decode boundary plus the 32-bit prefix
// detector, which decode reuses when it re-classifies issued instructions.
package core_issue_split_pkg;

  typedef logic [15:0] hword;
  typedef logic [31:0] word;
  typedef logic [30:0] hptr;

  typedef enum logic [1:0] {
    ISSUE_LO    = 2'd0,
    ISSUE_HI    = 2'd1,
    ISSUE_CARRY = 2'd2
  } issue_state;

  function automatic logic is_long_prefix(input hword hw);
    return (hw[15:11] == 5'b11101) || (hw[15:11] == 5'b11110) || (hw[15:11] == 5'b11111);
  endfunction

endpackage

// File: rtl/core_issue_split_if.sv
// Fetch-pair / decode-issue bundle around the issue splitter. The slave side is
// the splitter itself; the master side is the fetch+decode environment.
interface core_issue_split_if;
  import core_issue_split_pkg::*;

  logic flush;
  logic flush_half;
  logic pair_valid;
  hword lo_insn;
  hword hi_insn;
  hptr  lo_insn_pc;
  hptr  hi_insn_pc;
  logic decode_ready;
  logic stall;
  logic stall_half;
  logic insn_valid;
  word  insn;
  hptr  insn_pc;
  logic insn_long;

  modport slave (
    input  flush, flush_half, pair_valid, lo_insn, hi_insn, lo_insn_pc, hi_insn_pc,
    input  decode_ready,
    output stall, stall_half, insn_valid, insn, insn_pc, insn_long
  );

  modport master (
    output flush, flush_half, pair_valid, lo_insn, hi_insn, lo_insn_pc, hi_insn_pc,
    output decode_ready,
    input  stall, stall_half, insn_valid, insn, insn_pc, insn_long
  );

endinterface

// File: rtl/core_issue_skid.sv
// One-entry registered output stage towards decode: accepts a new instruction
// whenever it is empty or decode is taking the current one this cycle.
module core_issue_skid
  import core_issue_split_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  word  load_insn,
  input  hptr  load_pc,
  input  logic load_long,
  input  logic ready,
  output logic can_load,
  output logic valid,
  output word  insn,
  output hptr  pc,
  output logic is_long
);

  logic valid_reg;
  word  insn_reg;
  hptr  pc_reg;
  logic long_reg;

  assign can_load = !valid_reg || ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      insn_reg  <= '0;
      pc_reg    <= '0;
      long_reg  <= 1'b0;
    end else if (clr) begin
      // Anything decode takes in the flush cycle is already gone; the rest dies.
      valid_reg <= 1'b0;
    end else if (can_load) begin
      valid_reg <= load;
      if (load) begin
        insn_reg <= load_insn;
        pc_reg   <= load_pc;
        long_reg <= load_long;
      end
    end
  end

  assign valid   = valid_reg;
  assign insn    = insn_reg;
  assign pc      = pc_reg;
  assign is_long = long_reg;

endmodule

// File: rtl/core_issue_split.sv
// Splits fetch halfword pairs into one 16- or 32-bit instruction per cycle for
// decode, joining prefixes with suffixes, including across pair boundaries.
module core_issue_split
  import core_issue_split_pkg::*;
(
  input logic             clk,
  input logic             rst,
  core_issue_split_if.slave bus
);

  issue_state state_reg, state_next;
  hword       carry_hw_reg;
  hptr        carry_pc_reg;
  logic       carry_load;
  logic       issue;
  word        issue_insn;
  hptr        issue_pc;
  logic       issue_long;
  logic       can_load;
  logic       stall_c;
  logic       stall_half_c;

  logic out_valid;
  word  out_insn;
  hptr  out_pc;
  logic out_long;

  always_comb begin
    state_next   = state_reg;
    carry_load   = 1'b0;
    issue        = 1'b0;
    issue_insn   = '0;
    issue_pc     = '0;
    issue_long   = 1'b0;
    stall_c      = 1'b1;
    stall_half_c = 1'b0;

    if (rst) begin
      stall_c      = 1'b1;
      stall_half_c = 1'b0;
    end else if (bus.flush) begin
      stall_c      = 1'b0;
      stall_half_c = 1'b0;
      state_next   = bus.flush_half ? ISSUE_HI : ISSUE_LO;
    end else begin
      unique case (state_reg)
        ISSUE_LO: begin
          if (!bus.pair_valid) begin
            stall_c = 1'b0;
          end else if (can_load) begin
            issue    = 1'b1;
            issue_pc = bus.lo_insn_pc;
            if (is_long_prefix(bus.lo_insn)) begin
              issue_insn = {bus.lo_insn, bus.hi_insn};
              issue_long = 1'b1;
              stall_c    = 1'b0;
            end else begin
              issue_insn = {16'h0000, bus.lo_insn};
              state_next = ISSUE_HI;
            end
          end
        end

        ISSUE_HI: begin
          stall_half_c = 1'b1;
          if (bus.pair_valid && can_load) begin
            stall_c      = 1'b0;
            stall_half_c = 1'b0;
            if (is_long_prefix(bus.hi_insn)) begin
              // Suffix lives in the next pair's lo slot; park the prefix.
              carry_load = 1'b1;
              state_next = ISSUE_CARRY;
            end else begin
              issue      = 1'b1;
              issue_insn = {16'h0000, bus.hi_insn};
              issue_pc   = bus.hi_insn_pc;
              state_next = ISSUE_LO;
            end
          end
        end

        ISSUE_CARRY: begin
          if (!bus.pair_valid) begin
            stall_c = 1'b0;
          end else if (can_load) begin
            issue        = 1'b1;
            issue_insn   = {carry_hw_reg, bus.lo_insn};
            issue_pc     = carry_pc_reg;
            issue_long   = 1'b1;
            stall_half_c = 1'b1;
            state_next   = ISSUE_HI;
          end
        end

        default: begin
          state_next = ISSUE_LO;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ISSUE_LO;
      carry_hw_reg <= '0;
      carry_pc_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (bus.flush) begin
        carry_hw_reg <= '0;
        carry_pc_reg <= '0;
      end else if (carry_load) begin
        carry_hw_reg <= bus.hi_insn;
        carry_pc_reg <= bus.hi_insn_pc;
      end
    end
  end

  core_issue_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .clr       (bus.flush),
    .load      (issue),
    .load_insn (issue_insn),
    .load_pc   (issue_pc),
    .load_long (issue_long),
    .ready     (bus.decode_ready),
    .can_load  (can_load),
    .valid     (out_valid),
    .insn      (out_insn),
    .pc        (out_pc),
    .is_long   (out_long)
  );

  assign bus.stall      = stall_c;
  assign bus.stall_half = stall_half_c;
  assign bus.insn_valid = out_valid;
  assign bus.insn       = out_insn;
  assign bus.insn_pc    = out_pc;
  assign bus.insn_long  = out_long;

endmodule

// File: tb/tb_core_issue_split.sv
// Directed bench for core_issue_split: steps through hand-computed pair
// sequences and checks handshake and issued instruction after each step.
module tb_core_issue_split;

  logic clk;
  logic rst;
  int   pass_count;
  int   total_count;

  core_issue_split_if bus ();

  core_issue_split dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_count++;
    assert (obs === exp) pass_count++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] i,
                         input logic [30:0] pc, input logic lng);
    $display("txn %s: insn_valid=%0b insn=%08h pc=%08h long=%0b", tag,
             bus.insn_valid, bus.insn, bus.insn_pc, bus.insn_long);
    chk({tag, ".valid"}, {63'd0, bus.insn_valid}, {63'd0, v});
    if (v) begin
      chk({tag, ".insn"}, {32'd0, bus.insn}, {32'd0, i});
      chk({tag, ".pc"},   {33'd0, bus.insn_pc}, {33'd0, pc});
      chk({tag, ".long"}, {63'd0, bus.insn_long}, {63'd0, lng});
    end
  endtask

  task automatic chk_stall(input string tag, input logic s, input logic h);
    #1;
    chk({tag, ".stall"},      {63'd0, bus.stall},      {63'd0, s});
    chk({tag, ".stall_half"}, {63'd0, bus.stall_half}, {63'd0, h});
  endtask

  task automatic set_pair(input logic [30:0] lo_pc, input logic [15:0] lo, input logic [15:0] hi);
    bus.pair_valid = 1'b1;
    bus.lo_insn    = lo;
    bus.hi_insn    = hi;
    bus.lo_insn_pc = lo_pc;
    bus.hi_insn_pc = lo_pc + 31'd1;
  endtask

  task automatic drop_pair();
    bus.pair_valid = 1'b0;
  endtask

  initial begin
    pass_count       = 0;
    total_count      = 0;
    rst              = 1'b1;
    bus.flush        = 1'b0;
    bus.flush_half   = 1'b0;
    bus.pair_valid   = 1'b0;
    bus.lo_insn      = '0;
    bus.hi_insn      = '0;
    bus.lo_insn_pc   = '0;
    bus.hi_insn_pc   = '0;
    bus.decode_ready = 1'b1;

    // 1: reset, then idle
    tick();
    tick();
    chk_out("rst", 1'b0, 32'h0, 31'h0, 1'b0);
    chk("rst.insn", {32'd0, bus.insn}, 64'd0);
    chk_stall("rst", 1'b1, 1'b0);
    rst = 1'b0;
    chk_stall("idle", 1'b0, 1'b0);
    tick();
    chk_out("idle", 1'b0, 32'h0, 31'h0, 1'b0);

    // 2: two 16-bit halfwords
    set_pair(31'h100, 16'h2001, 16'h2102);
    chk_stall("t2.lo", 1'b1, 1'b0);
    tick();
    chk_out("t2.first", 1'b1, 32'h0000_2001, 31'h100, 1'b0);
    chk_stall("t2.hi", 1'b0, 1'b0);
    tick();
    drop_pair();
    chk_out("t2.second", 1'b1, 32'h0000_2102, 31'h101, 1'b0);
    chk_stall("t2.done", 1'b0, 1'b0);
    tick();
    chk_out("t2.drain", 1'b0, 32'h0, 31'h0, 1'b0);

    // 3: 32-bit instruction in one pair
    set_pair(31'h200, 16'hF000, 16'hB800);
    chk_stall("t3", 1'b0, 1'b0);
    tick();
    drop_pair();
    chk_out("t3.long", 1'b1, 32'hF000_B800, 31'h200, 1'b1);

    // 4: prefix in hi slot joined with next pair's lo
    set_pair(31'h300, 16'h2001, 16'hF7FF);
    chk_stall("t4.lo", 1'b1, 1'b0);
    tick();
    chk_out("t4.a", 1'b1, 32'h0000_2001, 31'h300, 1'b0);
    chk_stall("t4.carry_in", 1'b0, 1'b0);
    tick();
    chk_out("t4.gap", 1'b0, 32'h0, 31'h0, 1'b0);
    set_pair(31'h302, 16'hFFFE, 16'h2002);
    chk_stall("t4.carry_out", 1'b1, 1'b1);
    tick();
    chk_out("t4.b", 1'b1, 32'hF7FF_FFFE, 31'h301, 1'b1);
    chk_stall("t4.hi", 1'b0, 1'b0);
    tick();
    drop_pair();
    chk_out("t4.c", 1'b1, 32'h0000_2002, 31'h303, 1'b0);
    tick();
    chk_out("t4.drain", 1'b0, 32'h0, 31'h0, 1'b0);

    // 5: decode backpressure holds output and stalls fetch
    bus.decode_ready = 1'b0;
    set_pair(31'h400, 16'h1234, 16'h5678);
    tick();
    chk_out("t5.load", 1'b1, 32'h0000_1234, 31'h400, 1'b0);
    chk_stall("t5.blk0", 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out("t5.hold", 1'b1, 32'h0000_1234, 31'h400, 1'b0);
      chk_stall("t5.blk", 1'b1, 1'b1);
    end
    bus.decode_ready = 1'b1;
    chk_stall("t5.rel", 1'b0, 1'b0);
    tick();
    drop_pair();
    chk_out("t5.resume", 1'b1, 32'h0000_5678, 31'h401, 1'b0);
    tick();
    chk_out("t5.drain", 1'b0, 32'h0, 31'h0, 1'b0);

    // 6: flush with flush_half while a prefix sits in carry
    set_pair(31'h500, 16'h2003, 16'hF123);
    tick();
    chk_out("t6.a", 1'b1, 32'h0000_2003, 31'h500, 1'b0);
    tick();
    drop_pair();
    chk_stall("t6.carry_idle", 1'b0, 1'b0);
    bus.flush      = 1'b1;
    bus.flush_half = 1'b1;
    chk_stall("t6.flush", 1'b0, 1'b0);
    tick();
    bus.flush      = 1'b0;
    bus.flush_half = 1'b0;
    chk_out("t6.killed", 1'b0, 32'h0, 31'h0, 1'b0);
    set_pair(31'h600, 16'hF000, 16'h2004);
    chk_stall("t6.hi_first", 1'b0, 1'b0);
    tick();
    drop_pair();
    chk_out("t6.hi", 1'b1, 32'h0000_2004, 31'h601, 1'b0);
    tick();
    chk_out("t6.no_carry", 1'b0, 32'h0, 31'h0, 1'b0);

    // 7: flush kills a held output, then restarts at lo
    bus.decode_ready = 1'b0;
    set_pair(31'h700, 16'h1111, 16'h2222);
    tick();
    chk_out("t7.held", 1'b1, 32'h0000_1111, 31'h700, 1'b0);
    bus.flush = 1'b1;
    chk_stall("t7.flush", 1'b0, 1'b0);
    tick();
    bus.flush = 1'b0;
    chk_out("t7.killed", 1'b0, 32'h0, 31'h0, 1'b0);
    bus.decode_ready = 1'b1;
    chk_stall("t7.lo_again", 1'b1, 1'b0);
    tick();
    chk_out("t7.reissue", 1'b1, 32'h0000_1111, 31'h700, 1'b0);

    // 8: reset mid-operation drops everything
    rst = 1'b1;
    chk_stall("t8.rst", 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    drop_pair();
    chk_out("t8.rst", 1'b0, 32'h0, 31'h0, 1'b0);
    chk("t8.insn", {32'd0, bus.insn}, 64'd0);
    chk("t8.pc", {33'd0, bus.insn_pc}, 64'd0);
    chk_stall("t8.idle", 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
